// File: rtl/pong_round_controller.sv
// pong_round_controller: frame-rate pong sequencer for ball motion, serve delay, scoring and game state
module pong_round_controller #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BALL_HW      = 10,
  parameter int BALL_HH      = 15,
  parameter int SPEED_X      = 2,
  parameter int SPEED_Y      = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [9:0] p1_left,
  input  logic [9:0] p1_right,
  input  logic [9:0] p2_left,
  input  logic [9:0] p2_right,
  input  logic [8:0] p1_top,
  input  logic [8:0] p1_bottom,
  input  logic [8:0] p2_top,
  input  logic [8:0] p2_bottom,
  input  logic [8:0] gl_top,
  input  logic [8:0] gl_bottom,
  input  logic [8:0] gr_top,
  input  logic [8:0] gr_bottom,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [2:0] winner,
  output logic       point,
  output logic [1:0] state
);
  typedef enum logic [1:0] {SERVE, PLAY, POINT, GAME_OVER} state_t;
  localparam int CW = $clog2(SERVE_FRAMES + 1);
  localparam logic [CW-1:0] CLAST = CW'(SERVE_FRAMES - 1);
  localparam logic [9:0] CX  = 10'(SCREEN_W / 2);
  localparam logic [9:0] XL  = 10'(BALL_HW);
  localparam logic [9:0] XR  = 10'(SCREEN_W - 1 - BALL_HW);
  localparam logic [9:0] XLT = 10'(BALL_HW + SPEED_X);
  localparam logic [9:0] XRT = 10'(SCREEN_W - 1 - BALL_HW - SPEED_X);
  localparam logic [9:0] SX  = 10'(SPEED_X);
  localparam logic [8:0] CY  = 9'(SCREEN_H / 2);
  localparam logic [8:0] YT  = 9'(BALL_HH);
  localparam logic [8:0] YB  = 9'(SCREEN_H - 1 - BALL_HH);
  localparam logic [8:0] YTT = 9'(BALL_HH + SPEED_Y);
  localparam logic [8:0] YBT = 9'(SCREEN_H - 1 - BALL_HH - SPEED_Y);
  localparam logic [8:0] SY  = 9'(SPEED_Y);
  localparam logic [10:0] HW = 11'(BALL_HW);
  localparam logic [9:0] HH  = 10'(BALL_HH);
  localparam logic [3:0] WS  = 4'(WIN_SCORE);
  state_t st, st_n;
  logic [9:0] x, x_n;
  logic [8:0] y, y_n;
  logic dx, dx_n, dy, dy_n, pt, pt_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] s1, s1_n, s2, s2_n, sc;
  logic [2:0] win, win_n;
  logic ledge, redge, lgoal, rgoal, hit1, hit2;
  // Box edges are moved to the other side of each inequality so nothing can underflow
  function automatic logic ovl(input logic [9:0] bx, input logic [8:0] by, input logic [9:0] l, input logic [9:0] r,
                               input logic [8:0] t, input logic [8:0] b);
    return ({1'b0, bx} < {1'b0, r} + HW) && ({1'b0, bx} + HW > {1'b0, l}) &&
           ({1'b0, by} < {1'b0, b} + HH) && ({1'b0, by} + HH > {1'b0, t});
  endfunction
  assign ledge = !dx && x <= XLT;
  assign redge = dx && x >= XRT;
  assign lgoal = gl_top < y && y < gl_bottom;
  assign rgoal = gr_top < y && y < gr_bottom;
  assign hit1  = ovl(x, y, p1_left, p1_right, p1_top, p1_bottom);
  assign hit2  = ovl(x, y, p2_left, p2_right, p2_top, p2_bottom);
  assign sc    = dx ? s2 : s1;
  always_comb begin
    st_n = st;
    x_n = x;
    y_n = y;
    dx_n = dx;
    dy_n = dy;
    cnt_n = cnt;
    s1_n = s1;
    s2_n = s2;
    win_n = win;
    pt_n = 1'b0;
    case (st)
      SERVE: if (frame_tick) begin
        st_n = (cnt == CLAST) ? PLAY : SERVE;
        cnt_n = (cnt == CLAST) ? '0 : cnt + CW'(1);
      end
      PLAY: if (frame_tick) begin
        if ((ledge && lgoal) || (redge && rgoal)) begin
          st_n = POINT;
          pt_n = 1'b1;
          s1_n = (redge && s1 != WS) ? s1 + 4'd1 : s1;
          s2_n = (ledge && s2 != WS) ? s2 + 4'd1 : s2;
          x_n = CX;
          y_n = CY;
          dx_n = ledge;
          dy_n = 1'b1;
        end else begin
          if (ledge) begin
            x_n = XL;
            dx_n = 1'b1;
          end else if (redge) begin
            x_n = XR;
            dx_n = 1'b0;
          end else if (hit1 && !dx) dx_n = 1'b1;
          else if (hit2 && dx) dx_n = 1'b0;
          else x_n = dx ? x + SX : x - SX;
          if (!dy && y <= YTT) begin
            y_n = YT;
            dy_n = 1'b1;
          end else if (dy && y >= YBT) begin
            y_n = YB;
            dy_n = 1'b0;
          end else y_n = dy ? y + SY : y - SY;
        end
      end
      POINT: if (frame_tick) begin
        st_n = (sc == WS) ? GAME_OVER : SERVE;
        win_n = (sc == WS) ? (dx ? 3'd2 : 3'd1) : 3'd0;
      end
      GAME_OVER: if (start) begin
        st_n = SERVE;
        s1_n = '0;
        s2_n = '0;
        win_n = '0;
        dx_n = 1'b1;
        dy_n = 1'b1;
        cnt_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= SERVE;
      x <= CX;
      y <= CY;
      dx <= 1'b1;
      dy <= 1'b1;
      cnt <= '0;
      s1 <= '0;
      s2 <= '0;
      win <= '0;
      pt <= 1'b0;
    end else begin
      st <= st_n;
      x <= x_n;
      y <= y_n;
      dx <= dx_n;
      dy <= dy_n;
      cnt <= cnt_n;
      s1 <= s1_n;
      s2 <= s2_n;
      win <= win_n;
      pt <= pt_n;
    end
  assign ball_x = x;
  assign ball_y = y;
  assign score_p1 = s1;
  assign score_p2 = s2;
  assign winner = win;
  assign point = pt;
  assign state = st;
endmodule

// File: tb/tb_pong_round_controller.sv
// tb_pong_round_controller: directed vectors and hand-written sequences for the pong sequencer
module tb_pong_round_controller;
  logic clk = 0, reset = 0, frame_tick = 0, start = 0;
  logic [9:0] p1_left, p1_right, p2_left, p2_right;
  logic [8:0] p1_top, p1_bottom, p2_top, p2_bottom, gl_top, gl_bottom, gr_top, gr_bottom;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic [3:0] score_p1, score_p2;
  logic [2:0] winner;
  logic point;
  logic [1:0] state;
  int total = 0, bad = 0, pt_count = 0;
  typedef struct { int n; int x; int y; int st; } vec_t;
  vec_t tv[9];
  pong_round_controller dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .p1_left(p1_left), .p1_right(p1_right), .p2_left(p2_left), .p2_right(p2_right),
    .p1_top(p1_top), .p1_bottom(p1_bottom), .p2_top(p2_top), .p2_bottom(p2_bottom),
    .gl_top(gl_top), .gl_bottom(gl_bottom), .gr_top(gr_top), .gr_bottom(gr_bottom),
    .ball_x(ball_x), .ball_y(ball_y), .score_p1(score_p1), .score_p2(score_p2),
    .winner(winner), .point(point), .state(state)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (point) pt_count++;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) frame_tick = 1;
      @(negedge clk) frame_tick = 0;
    end
  endtask
  task automatic park;
    {p1_left, p1_right, p2_left, p2_right} = '0;
    {p1_top, p1_bottom, p2_top, p2_bottom} = '0;
    gl_top = 0; gl_bottom = 1; gr_top = 0; gr_bottom = 1;
  endtask
  task automatic do_reset;
    @(negedge clk) reset = 0;
    @(negedge clk) reset = 1;
  endtask
  task automatic until_point(input int lim);
    int i;
    for (i = 0; i < lim && !point; i++) tick(1);
    chk("point_timeout", point, 1);
  endtask
  task automatic chk_ball(input string nm, input int ex, input int ey, input int es);
    chk({nm, "_x"}, ball_x, ex);
    chk({nm, "_y"}, ball_y, ey);
    chk({nm, "_st"}, state, es);
  endtask
  initial begin
    tv[0] = '{0, 320, 240, 0};
    tv[1] = '{59, 320, 240, 0};
    tv[2] = '{1, 320, 240, 1};
    tv[3] = '{1, 322, 242, 1};
    tv[4] = '{111, 544, 464, 1};
    tv[5] = '{1, 546, 462, 1};
    tv[6] = '{41, 628, 380, 1};
    tv[7] = '{1, 629, 378, 1};
    tv[8] = '{1, 627, 376, 1};
    park();
    repeat (2) @(negedge clk);
    reset = 1;
    chk("rst_s1", score_p1, 0);
    chk("rst_s2", score_p2, 0);
    chk("rst_win", winner, 0);
    chk("rst_pt", point, 0);
    for (int i = 0; i < 9; i++) begin
      tick(tv[i].n);
      chk_ball($sformatf("vec%0d", i), tv[i].x, tv[i].y, tv[i].st);
    end
    chk("no_point", pt_count, 0);
    // P2 paddle bounce: left edge 533 first overlaps at x=524
    do_reset();
    p2_left = 533; p2_right = 585; p2_top = 200; p2_bottom = 500;
    tick(162);
    chk_ball("pad0", 524, 444, 1);
    tick(1);
    chk_ball("pad1", 524, 446, 1);
    tick(1);
    chk_ball("pad2", 522, 448, 1);
    tick(1);
    chk_ball("pad3", 520, 450, 1);
    // right goal scoring
    do_reset();
    park();
    gr_top = 300; gr_bottom = 500;
    tick(214);
    chk_ball("g0", 628, 380, 1);
    tick(1);
    chk_ball("g1", 320, 240, 2);
    chk("g1_pt", point, 1);
    chk("g1_s1", score_p1, 1);
    @(negedge clk);
    chk("g1_pt_off", point, 0);
    tick(1);
    chk("g1_serve", state, 0);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    chk("start_ign_st", state, 0);
    chk("start_ign_s1", score_p1, 1);
    tick(61);
    chk_ball("serve_dir", 318, 242, 1);
    gr_top = 0;
    for (int k = 2; k <= 5; k++) begin
      until_point(1200);
      chk($sformatf("s1_%0d", k), score_p1, k);
      chk($sformatf("s2_%0d", k), score_p2, 0);
      tick(1);
      chk($sformatf("after_%0d", k), state, k == 5 ? 3 : 0);
    end
    chk("win", winner, 1);
    tick(3);
    chk_ball("go_hold", 320, 240, 3);
    chk("go_s1", score_p1, 5);
    @(negedge clk) begin start = 1; frame_tick = 1; end
    @(negedge clk) begin start = 0; frame_tick = 0; end
    chk("restart_st", state, 0);
    chk("restart_s1", score_p1, 0);
    chk("restart_win", winner, 0);
    tick(59);
    chk("restart_59", state, 0);
    tick(1);
    chk("restart_60", state, 1);
    tick(1);
    chk_ball("restart_mv", 322, 242, 1);
    // left goal: P2 scores and serves toward itself
    gl_top = 0; gl_bottom = 500; gr_top = 0; gr_bottom = 1;
    until_point(1200);
    chk("p2_s2", score_p2, 1);
    chk("p2_s1", score_p1, 0);
    chk_ball("p2_pt", 320, 240, 2);
    tick(62);
    chk_ball("p2_serve", 322, 242, 1);
    // asynchronous reset between edges
    tick(5);
    @(negedge clk);
    #2 reset = 0;
    #1;
    chk_ball("arst", 320, 240, 0);
    chk("arst_s2", score_p2, 0);
    chk("arst_pt", point, 0);
    reset = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
